// File: rtl/video_in_store.sv
// Drains the packed-pixel FIFO into the frame buffer as fixed-length Wishbone classic write bursts.
// Define VIDEO_IN_STORE_DOUBLE_BUF_EN to alternate successive frames between two buffers.
`timescale 1ns/1ps
module video_in_store #(
   parameter int p_WIDTH   = 640,
   parameter int p_HEIGHT  = 480,
   parameter int p_BURST   = 16,
   parameter int p_LEVEL_W = 8
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic [31:0]          fifo_data,
   input  logic [p_LEVEL_W-1:0] fifo_level,
   output logic                 fifo_r_e,
   input  logic [31:0]          base_addr,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [31:0]          wb_adr_o,
   output logic [31:0]          wb_dat_o,
   output logic [3:0]           wb_sel_o,
   input  logic                 wb_ack_i,
   output logic                 frame_done,
   output logic                 buf_sel
);

   localparam int          N       = p_WIDTH * p_HEIGHT / 4;
   localparam int          WCW     = $clog2(N + 1);
   localparam int          BW      = $clog2(p_BURST + 1);
   localparam logic [31:0] BURST_U = 32'(p_BURST);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

   state_t           state_q;
   logic [WCW-1:0]   word_cnt_q, word_cnt_d;
   logic [BW-1:0]    beat_q;
   logic [31:0]      frame_base_q, frame_base_d;
   logic [31:0]      adr_q, adr_d, burst_adr_d;
   logic             cyc_q, we_q, frame_done_q;
   logic [3:0]       sel_q;

`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
   logic             buf_sel_q;
   assign frame_base_d = base_addr + (buf_sel_q ? 32'(4 * N) : 32'd0);
   assign buf_sel      = buf_sel_q;
`else
   assign frame_base_d = base_addr;
   assign buf_sel      = 1'b0;
`endif

   assign word_cnt_d  = word_cnt_q + 1'b1;
   assign adr_d       = adr_q + 32'd4;
   assign burst_adr_d = frame_base_q + (32'(word_cnt_q) << 2);

   // Strobe and cycle are identical in classic single-master bursts; the pop is the accepted beat.
   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = cyc_q;
   assign wb_we_o    = we_q;
   assign wb_sel_o   = sel_q;
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = cyc_q ? fifo_data : 32'd0;
   assign fifo_r_e   = wb_stb_o & wb_ack_i;
   assign frame_done = frame_done_q;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q      <= S_IDLE;
         word_cnt_q   <= '0;
         beat_q       <= '0;
         frame_base_q <= '0;
         adr_q        <= '0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= 4'h0;
         frame_done_q <= 1'b0;
`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
         buf_sel_q    <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (word_cnt_q == '0) begin
                  frame_base_q <= frame_base_d;
               end
               state_q <= S_WAIT;
            end
            // A full burst must already be buffered so the FIFO never underflows mid-burst.
            S_WAIT: begin
               if (32'(fifo_level) >= BURST_U) begin
                  cyc_q   <= 1'b1;
                  we_q    <= 1'b1;
                  sel_q   <= 4'hF;
                  adr_q   <= burst_adr_d;
                  beat_q  <= '0;
                  state_q <= S_BURST;
               end
            end
            S_BURST: begin
               if (wb_stb_o && wb_ack_i) begin
                  word_cnt_q <= word_cnt_d;
                  adr_q      <= adr_d;
                  beat_q     <= beat_q + 1'b1;
                  if (beat_q == BW'(p_BURST - 1)) begin
                     cyc_q        <= 1'b0;
                     we_q         <= 1'b0;
                     sel_q        <= 4'h0;
                     beat_q       <= '0;
                     frame_done_q <= (word_cnt_d == WCW'(N));
                     state_q      <= (word_cnt_d == WCW'(N)) ? S_DONE : S_WAIT;
                  end
               end
            end
            S_DONE: begin
               word_cnt_q <= '0;
`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
               buf_sel_q  <= ~buf_sel_q;
`endif
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/video_in_store.md
Name: video_in_store

Overview:
- Downstream stage of the video input path, in the 100 MHz system clock domain.
- Drains the 32-bit packed-pixel FIFO, which the video input reader fills at one word per 4 pixels.
- Writes the words into the frame buffer in memory as fixed-length Wishbone classic write bursts, at consecutive addresses from a frame base address.
- Signals the end of each full frame to software and the display path.

Parameters:
- p_WIDTH, 640, active pixels per line
- p_HEIGHT, 480, active lines per frame
- p_BURST, 16, words per Wishbone burst; (p_WIDTH*p_HEIGHT/4) must be a multiple of p_BURST
- p_LEVEL_W, 8, width of FIFO fill-level input

Ports:
- clk  in  1  system clock, 100 MHz
- nRST  in  1  asynchronous active-low reset
- fifo_data  in  32  FIFO head word, first-word-fall-through
- fifo_level  in  p_LEVEL_W  number of words in FIFO
- fifo_r_e  out  1  pop FIFO head on this clk edge
- base_addr  in  32  frame buffer byte base address, 4-byte aligned
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable; always 1 while wb_cyc_o=1
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte selects; 4'hF during a cycle, 0 otherwise
- wb_ack_i  in  1  slave acknowledge
- frame_done  out  1  one-cycle pulse after last word of a frame is acked
- buf_sel  out  1  frame buffer index currently being written

Behaviour:
- Reset values: all outputs 0; word_cnt=0; frame_base=0; state=IDLE.
- Reset is asynchronous and takes effect mid-burst: cyc/stb drop immediately and the partial frame is abandoned.
- Per-frame words: N = p_WIDTH*p_HEIGHT/4 (76800 at defaults); word_cnt is 17 bits for defaults, sized by $clog2(N+1).
- States:
  - IDLE: if word_cnt==0, latch frame_base <= base_addr (plus offset, see Optional Feature); go to WAIT.
  - WAIT: when fifo_level >= p_BURST, go to BURST next cycle. Register wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=F, wb_adr_o=frame_base + 4*word_cnt.
  - BURST: stb held high across beats, wb_dat_o = fifo_data (combinational from FIFO head).
    - On each cycle with wb_ack_i=1: fifo_r_e=1 (combinational, wb_stb_o & wb_ack_i), word_cnt+1, wb_adr_o+4 registered, beat count+1.
    - On the p_BURST-th ack: cyc/stb/sel drop to 0 on the next edge.
    - If word_cnt reached N, go to DONE; else go to WAIT.
  - DONE: frame_done=1 for exactly one cycle, word_cnt <= 0, go to IDLE.
- Minimum gap between bursts: 1 idle cycle with cyc=0. A new burst never starts with fewer than p_BURST words available, so the FIFO cannot underflow mid-burst.
- Ack held low stalls indefinitely; data and address remain stable while stb=1 and ack=0.
- wb_ack_i while wb_stb_o=0 is ignored: no pop, no count.
- base_addr changes mid-frame have no effect until the next frame start.
- Address arithmetic is 32-bit modulo 2^32, with no overflow detection.
- fifo_level is never decremented by this block; it is sampled only in WAIT.

Optional Feature:
- Macro: VIDEO_IN_STORE_DOUBLE_BUF_EN.
- Enabled:
  - buf_sel toggles in DONE.
  - At frame start, frame_base = base_addr + (buf_sel ? 4*N : 0), so successive frames alternate between two buffers.
  - buf_sel reset value 0.
- Disabled: buf_sel tied 0; frame_base = base_addr every frame.

Test Plan:
- Reset then fifo_level=16, base_addr=0x1000_0000, ack every cycle -> one 16-beat burst, addresses 0x1000_0000..0x1000_003C, 16 fifo_r_e pulses, cyc drops after beat 16.
- fifo_level=15 held -> no cyc for 100 cycles. Raise to 16 -> cyc asserts within 2 cycles.
- Ack asserted on alternate cycles -> each beat's adr/dat held stable through the wait cycle; exactly 16 pops per burst.
- Full frame of 76800 words with random ack stalls -> 4800 bursts, last address base+0x4AFFC, exactly one frame_done pulse. With VIDEO_IN_STORE_DOUBLE_BUF_EN, second frame starts at base+0x4B000 and buf_sel=1.
- nRST asserted at beat 7 of a burst -> cyc/stb/sel 0 immediately. After release, the next burst restarts at base_addr with word_cnt=0.
- base_addr changed to 0x2000_0000 mid-frame -> current frame continues at the old base; the next frame starts at 0x2000_0000.
